// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared constants and state type for parity_rx9
// Purpose: frame geometry and receiver state encoding used by parity_rx9.
// Contents: DATA_W (data bits per frame), FRAME_W (data + parity bits), state_t.
package parity_pkg;

   localparam int DATA_W  = 9;
   localparam int FRAME_W = 10;

   typedef enum logic {
      SHIFT = 1'b0,
      HOLD  = 1'b1
   } state_t;

endpackage

// File: rtl/xorpar.sv
// rtl/xorpar.sv - combinational 9-bit parity (XOR reduction)
// Purpose: returns the XOR of all nine input bits.
// Ports: data_i [8:0] bits to reduce, par_o XOR of data_i.
module xorpar (
   input  logic [8:0] data_i,
   output logic       par_o
);

   assign par_o = ^data_i;

endmodule

// File: rtl/parity_rx9.sv
// rtl/parity_rx9.sv - serial 9-bit + parity frame receiver with output handshake
// Purpose: shifts in 9 data bits LSB-first plus one parity bit, then presents the
//          word and its parity-error flag until the consumer takes it.
// Ports: clk, rst (synchronous, active-high)
//        in_bit / in_valid / in_ready : serial bit input handshake
//        out_data / out_perr / out_valid / out_ready : frame output handshake
//        err_cnt : saturating parity-error count, only with PARITY_RX9_ERRCNT_EN
// Optional feature macro: PARITY_RX9_ERRCNT_EN
module parity_rx9
   import parity_pkg::*;
#(
   parameter int ODD_PARITY = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_bit,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_perr,
   output logic              out_valid,
   input  logic              out_ready
`ifdef PARITY_RX9_ERRCNT_EN
   ,
   output logic [7:0]        err_cnt
`endif
);

   localparam logic       ODD_BIT  = (ODD_PARITY != 0);
   localparam logic [3:0] LAST_IDX = 4'(FRAME_W - 1);

   state_t              state_q;
   logic [3:0]          cnt_q;
   logic [DATA_W-1:0]   sr_q;
   logic [DATA_W-1:0]   sr_d;
   logic [DATA_W-1:0]   data_q;
   logic                perr_q;
   logic                perr_d;
   logic                valid_q;
   logic                ready_q;
   logic                sr_par;
   logic                accept;
   logic                handshake;

   xorpar u_xorpar (
      .data_i (sr_q),
      .par_o  (sr_par)
   );

   // ready_q is only ever 1 in SHIFT and valid_q only in HOLD, so these
   // handshakes already ignore the inactive side's signals.
   assign accept    = in_valid & ready_q;
   assign handshake = valid_q & out_ready;

   // New bits enter at the top so the first bit ends up in bit 0.
   always_comb begin
      sr_d   = {in_bit, sr_q[DATA_W-1:1]};
      perr_d = sr_par ^ in_bit ^ ODD_BIT;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SHIFT;
         cnt_q   <= 4'd0;
         sr_q    <= '0;
         data_q  <= '0;
         perr_q  <= 1'b0;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         case (state_q)
            SHIFT: begin
               if (accept) begin
                  if (cnt_q == LAST_IDX) begin
                     // Parity bit: sr_q already holds all nine data bits.
                     data_q  <= sr_q;
                     perr_q  <= perr_d;
                     valid_q <= 1'b1;
                     ready_q <= 1'b0;
                     state_q <= HOLD;
                  end else begin
                     sr_q  <= sr_d;
                     cnt_q <= cnt_q + 4'd1;
                  end
               end
            end
            HOLD: begin
               if (handshake) begin
                  cnt_q   <= 4'd0;
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
                  state_q <= SHIFT;
               end
            end
            default: state_q <= SHIFT;
         endcase
      end
   end

   assign in_ready  = ready_q;
   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_perr  = perr_q;

`ifdef PARITY_RX9_ERRCNT_EN
   logic [7:0] err_cnt_q;
   logic [7:0] err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (handshake && perr_q && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt_q <= 8'd0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_rx9.sv
// tb/tb_parity_rx9.sv - scoreboard bench for parity_rx9 (even and odd instances)
module tb_parity_rx9;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_bit = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [8:0] data_e, data_o;
   logic       perr_e, perr_o, vld_e, vld_o, rdy_e, rdy_o;
`ifdef PARITY_RX9_ERRCNT_EN
   logic [7:0] ec_e, ec_o;
`endif

   int tests = 0;
   int fails = 0;
   int bad_e = 0;
   int bad_o = 0;
   bit rand_ready = 1'b0;
   bit prev_hs = 1'b0;

   typedef struct {
      logic [8:0] d;
      logic       p;
   } exp_t;

   exp_t q_e[$];
   exp_t q_o[$];

   parity_rx9 #(.ODD_PARITY(0)) u_even (
      .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_ready(rdy_e),
      .out_data(data_e), .out_perr(perr_e), .out_valid(vld_e), .out_ready(out_ready)
`ifdef PARITY_RX9_ERRCNT_EN
      , .err_cnt(ec_e)
`endif
   );

   parity_rx9 #(.ODD_PARITY(1)) u_odd (
      .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_ready(rdy_o),
      .out_data(data_o), .out_perr(perr_o), .out_valid(vld_o), .out_ready(out_ready)
`ifdef PARITY_RX9_ERRCNT_EN
      , .err_cnt(ec_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference rule: the total count of ones over data, parity bit and the
   // mode bit must be even for a clean frame.
   function automatic logic model_perr(input logic [8:0] d, input logic p, input int odd);
      int s;
      s = $countones(d) + int'(p) + odd;
      return (s % 2) == 1;
   endfunction

   function automatic logic even_good_par(input logic [8:0] d);
      return ($countones(d) % 2) == 1;
   endfunction

   task automatic push_exp(input logic [8:0] d, input logic p);
      exp_t e;
      e.d = d;
      e.p = model_perr(d, p, 0);
      q_e.push_back(e);
      e.p = model_perr(d, p, 1);
      q_o.push_back(e);
   endtask

   task automatic put_bit(input logic b);
      int  n;
      logic r;
      n = 0;
      in_valid = 1'b1;
      in_bit   = b;
      do begin
         @(negedge clk);
         r = rdy_e;
         @(posedge clk);
         #1;
         n++;
      end while (!r && n < 3000);
      in_valid = 1'b0;
      if (!r) check("accept_timeout", int'(r), 1);
   endtask

   task automatic send_frame(input logic [8:0] d, input logic p, input int gap_max);
      int gap;
      for (int i = 0; i < 10; i++) begin
         gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
         put_bit((i < 9) ? d[i] : p);
      end
      push_exp(d, p);
      check("valid_latency", int'(vld_e), 1);
      check("valid_latency_odd", int'(vld_o), 1);
   endtask

   task automatic do_reset();
      rand_ready = 1'b0;
      out_ready  = 1'b0;
      in_valid   = 1'b0;
      q_e.delete();
      q_o.delete();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bad_e = 0;
      bad_o = 0;
      prev_hs = 1'b0;
      @(negedge clk);
      check("rst_in_ready", int'(rdy_e), 1);
      check("rst_in_ready_odd", int'(rdy_o), 1);
      check("rst_out_valid", int'(vld_e | vld_o), 0);
      check("rst_out_data", int'(data_e | data_o), 0);
      check("rst_out_perr", int'(perr_e | perr_o), 0);
`ifdef PARITY_RX9_ERRCNT_EN
      check("rst_err_cnt", int'(ec_e), 0);
      check("rst_err_cnt_odd", int'(ec_o), 0);
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q_e.size() != 0 || q_o.size() != 0) && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_even", q_e.size(), 0);
      check("drain_odd", q_o.size(), 0);
   endtask

   // Monitor: pops and compares on every output handshake.
   initial begin
      exp_t e;
      bit   hs;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (vld_e || vld_o) begin
               check("valid_lockstep", int'(vld_o), int'(vld_e));
               check("in_ready_in_hold", int'(rdy_e | rdy_o), 0);
            end
            if (prev_hs) check("valid_one_cycle", int'(vld_e), 0);
            hs = vld_e && out_ready;
            if (hs) begin
               if (q_e.size() == 0) begin
                  check("unexpected_frame", q_e.size(), 1);
               end else begin
                  e = q_e.pop_front();
                  check("data_even", int'(data_e), int'(e.d));
                  check("perr_even", int'(perr_e), int'(e.p));
                  if (e.p) bad_e++;
               end
            end
            if (vld_o && out_ready) begin
               if (q_o.size() == 0) begin
                  check("unexpected_frame_odd", q_o.size(), 1);
               end else begin
                  e = q_o.pop_front();
                  check("data_odd", int'(data_o), int'(e.d));
                  check("perr_odd", int'(perr_o), int'(e.p));
                  if (e.p) bad_o++;
               end
            end
            prev_hs = hs;
         end
      end
   end

   // Random backpressure driver, active only when rand_ready is set.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (rand_ready) out_ready = ($urandom_range(0, 1) == 1);
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: time %0t exceeded limit 3000000", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0] d;
      int         held;

      do_reset();

      // Zero frame, consumer always ready.
      out_ready = 1'b1;
      send_frame(9'h000, 1'b0, 0);
      drain();

      // All-ones data with good and bad even parity.
      send_frame(9'h1FF, 1'b1, 0);
      send_frame(9'h1FF, 1'b0, 0);
      drain();

      // Input gap after bit 4, then consumer stalls for 5 cycles.
      out_ready = 1'b0;
      d = 9'h0A5;
      for (int i = 0; i < 5; i++) put_bit(d[i]);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      for (int i = 5; i < 9; i++) put_bit(d[i]);
      put_bit(even_good_par(d));
      push_exp(d, even_good_par(d));
      held = 0;
      repeat (5) begin
         @(negedge clk);
         if (vld_e && data_e == 9'h0A5) held++;
      end
      check("hold_cycles", held, 5);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain();

      // Reset mid-frame, then one full frame.
      d = 9'h0F3;
      for (int i = 0; i < 4; i++) put_bit(d[i]);
      do_reset();
      out_ready = 1'b1;
      send_frame(9'h123, even_good_par(9'h123), 0);
      drain();

      // Reset while a frame is pending in HOLD.
      out_ready = 1'b0;
      send_frame(9'h155, 1'b0, 0);
      q_e.delete();
      q_o.delete();
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      do_reset();
      out_ready = 1'b1;
      send_frame(9'h0F0, 1'b1, 0);
      drain();

      // Odd-mode corner: data 0x001.
      send_frame(9'h001, 1'b0, 0);
      send_frame(9'h001, 1'b1, 0);
      drain();

      // Random data, parity, input gaps and backpressure.
      rand_ready = 1'b1;
      for (int k = 0; k < 150; k++) begin
         send_frame(9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)), 2);
      end
      rand_ready = 1'b0;
      @(posedge clk);
      #3;
      out_ready = 1'b1;
      drain();

      // Sweep all data values with correct even, then correct odd parity.
      for (int k = 0; k < 512; k++) send_frame(9'(k), even_good_par(9'(k)), 0);
      for (int k = 0; k < 512; k++) send_frame(9'(k), ~even_good_par(9'(k)), 0);
      drain();

`ifdef PARITY_RX9_ERRCNT_EN
      do_reset();
      out_ready = 1'b1;
      for (int k = 0; k < 300; k++) begin
         d = 9'($urandom_range(0, 511));
         send_frame(d, ~even_good_par(d), 0);
      end
      drain();
      check("err_cnt_sat", int'(ec_e), (bad_e > 255) ? 255 : bad_e);
      check("err_cnt_odd", int'(ec_o), (bad_o > 255) ? 255 : bad_o);
      do_reset();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
